// File: rtl/cpu_run_controller.sv
// cpu_run_controller: sequences CPU reset, times the run and returns a pass/fail/timeout verdict from tohost stores
module cpu_run_controller #(
    parameter int                    RESET_CYCLES   = 4,
    parameter int                    TIMEOUT_CYCLES = 100,
    parameter int                    CNT_WIDTH      = 32,
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR    = 'h1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  restart,
    input  logic                  st_en,
    input  logic [ADDR_WIDTH-1:0] st_addr,
    input  logic [DATA_WIDTH-1:0] st_data,
    output logic                  cpu_rst,
    output logic                  running,
    output logic                  done,
    output logic                  pass,
    output logic                  fail,
    output logic                  timeout,
    output logic [DATA_WIDTH-1:0] fail_code,
    output logic [CNT_WIDTH-1:0]  cycle_count
);
    typedef enum logic [2:0] {S_RESET, S_RUN, S_PASS, S_FAIL, S_TIMEOUT} state_t;
    localparam int RW = $clog2(RESET_CYCLES + 1);

    state_t                state, state_n;
    logic [RW-1:0]         rcnt, rcnt_n;
    logic [CNT_WIDTH-1:0]  cnt_n;
    logic [DATA_WIDTH-1:0] code_n;
    logic                  hit;

    assign hit = st_en && st_addr == TOHOST_ADDR && st_data != '0;

    // every output is a pure decode of the state register, so nothing combinational reaches the ports
    assign cpu_rst = state != S_RUN;
    assign running = state == S_RUN;
    assign pass    = state == S_PASS;
    assign fail    = state == S_FAIL;
    assign timeout = state == S_TIMEOUT;
    assign done    = pass | fail | timeout;

    // next state: reset countdown, run watch (hit beats watchdog), sticky verdict until restart
    always_comb begin
        state_n = state;
        rcnt_n  = rcnt;
        cnt_n   = cycle_count;
        code_n  = fail_code;
        case (state)
            S_RESET: begin
                if (rcnt == RW'(RESET_CYCLES - 1)) begin
                    state_n = S_RUN;
                    cnt_n   = '0;
                end else begin
                    rcnt_n = rcnt + 1'b1;
                end
            end
            S_RUN: begin
                if (hit) begin
                    state_n = st_data == DATA_WIDTH'(1) ? S_PASS : S_FAIL;
                    code_n  = st_data == DATA_WIDTH'(1) ? fail_code : st_data >> 1;
                end else if (cycle_count == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                    state_n = S_TIMEOUT;
                end else begin
                    cnt_n = cycle_count + 1'b1;
                end
            end
            default: begin
                if (restart) begin
                    state_n = S_RESET;
                    rcnt_n  = '0;
                    code_n  = '0;
                end
            end
        endcase
    end

    // state and counters, rst wins over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_RESET;
            rcnt        <= '0;
            cycle_count <= '0;
            fail_code   <= '0;
        end else begin
            state       <= state_n;
            rcnt        <= rcnt_n;
            cycle_count <= cnt_n;
            fail_code   <= code_n;
        end
    end
endmodule

// File: tb/tb_cpu_run_controller.sv
// tb_cpu_run_controller: directed and random checks of cpu_run_controller against a behavioural model
module tb_cpu_run_controller;
    localparam int          RC = 4;
    localparam int          TO = 100;
    localparam logic [31:0] TH = 32'h1000;

    logic        clk = 0, rst = 1, restart = 0, st_en = 0;
    logic [31:0] st_addr = 0, st_data = 0;
    logic        cpu_rst, running, done, pass, fail, timeout;
    logic [31:0] fail_code, cycle_count;

    int total = 0, bad = 0;

    // model: are we counting reset edges, how many so far, and the verdict (0 none, 1 pass, 2 fail, 3 timeout)
    bit          m_hold = 1;
    int          m_redges = 0, m_verdict = 0;
    longint      m_cnt = 0;
    logic [31:0] m_code = 0;

    cpu_run_controller dut (
        .clk(clk), .rst(rst), .restart(restart), .st_en(st_en), .st_addr(st_addr), .st_data(st_data),
        .cpu_rst(cpu_rst), .running(running), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
        .fail_code(fail_code), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit rs, input bit en, input logic [31:0] a, input logic [31:0] d);
        if (r) begin
            m_hold = 1; m_redges = 0; m_verdict = 0; m_cnt = 0; m_code = 0;
        end else if (m_verdict != 0) begin
            if (rs) begin m_verdict = 0; m_hold = 1; m_redges = 0; m_code = 0; end
        end else if (m_hold) begin
            m_redges++;
            if (m_redges == RC) begin m_hold = 0; m_cnt = 0; end
        end else if (en && a == TH && d != 0) begin
            m_verdict = (d == 1) ? 1 : 2;
            if (d != 1) m_code = d >> 1;
        end else if (m_cnt == TO - 1) begin
            m_verdict = 3;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic step(input bit r, input bit rs, input bit en, input logic [31:0] a, input logic [31:0] d);
        rst = r; restart = rs; st_en = en; st_addr = a; st_data = d;
        @(posedge clk);
        model_step(r, rs, en, a, d);
        #1;
        chk("cpu_rst", cpu_rst, m_hold || m_verdict != 0);
        chk("running", running, !m_hold && m_verdict == 0);
        chk("done", done, m_verdict != 0);
        chk("pass", pass, m_verdict == 1);
        chk("fail", fail, m_verdict == 2);
        chk("timeout", timeout, m_verdict == 3);
        chk("fail_code", fail_code, m_code);
        chk("cycle_count", cycle_count, m_cnt);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("rst_cpu_rst", cpu_rst, 1);
        idle(RC - 1);
        chk("rst_hold_last", cpu_rst, 1);
        idle(1);
        chk("rst_release", cpu_rst, 0);
        chk("rst_running", running, 1);
        idle(9);
        step(0, 0, 1, TH, 1);
        chk("pass_flag", pass, 1);
        chk("pass_cnt", cycle_count, 9);
        chk("pass_cpu_rst", cpu_rst, 1);
        step(0, 0, 1, TH, 7);
        idle(19);
        chk("pass_sticky", pass, 1);
        step(0, 1, 0, 0, 0);
        chk("restart_done", done, 0);
        chk("restart_cnt_kept", cycle_count, 9);
        idle(RC - 1);
        chk("restart_hold", cpu_rst, 1);
        idle(1);
        chk("restart_release", cpu_rst, 0);
        chk("restart_cnt0", cycle_count, 0);
        step(0, 1, 0, 0, 0);
        chk("restart_in_run", running, 1);
        step(0, 0, 1, TH, 0);
        step(0, 0, 1, 32'h0FFC, 7);
        chk("filter_running", running, 1);
        step(0, 0, 1, TH, 7);
        chk("fail_flag", fail, 1);
        chk("fail_code3", fail_code, 3);
        step(0, 1, 0, 0, 0);
        idle(RC);
        idle(TO);
        chk("to_flag", timeout, 1);
        chk("to_cnt", cycle_count, TO - 1);
        step(0, 1, 0, 0, 0);
        idle(RC);
        idle(TO - 1);
        chk("coll_pre", running, 1);
        step(0, 0, 1, TH, 1);
        chk("coll_pass", pass, 1);
        chk("coll_no_to", timeout, 0);
        chk("coll_cnt", cycle_count, TO - 1);
        step(0, 1, 0, 0, 0);
        idle(RC);
        idle(49);
        step(1, 0, 1, TH, 1);
        chk("abort_pass", pass, 0);
        chk("abort_cnt", cycle_count, 0);
        chk("abort_cpu_rst", cpu_rst, 1);
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] d;
            case ($urandom_range(0, 3))
                0: d = 0;
                1: d = 1;
                default: d = $urandom;
            endcase
            step($urandom_range(0, 299) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 1) ? TH : 32'($urandom_range(0, 8191)), d);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cpu_run_controller.md
# cpu_run_controller

Synthesizable run controller for CPU simulation and FPGA bring-up. It sequences the CPU reset, counts cycles while the core runs, and watches the core's store bus for a tohost write. It ends the run as pass, fail (with code) or timeout. It sits between the top-level clock/reset and CPUTop, and replaces hard-coded reset pulses and fixed-delay finish logic with a parametrised, checkable verdict.

## Interface
Parameters:
- RESET_CYCLES, 4: number of clock edges with rst low during which cpu_rst stays high; legal range ≥ 1.
- TIMEOUT_CYCLES, 100: maximum run length in cycles; legal range ≥ 1.
- CNT_WIDTH, 32: width of cycle_count; must hold TIMEOUT_CYCLES-1.
- ADDR_WIDTH, 32: store address width.
- DATA_WIDTH, 32: store data width.
- TOHOST_ADDR, 32'h0000_1000: magic store address that ends the run.

Ports (clock and reset first):
- clk  in  1  system clock; everything is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- restart  in  1  single-cycle request to rerun; honoured only in a terminal state.
- st_en  in  1  CPU store valid this cycle.
- st_addr  in  ADDR_WIDTH  CPU store address.
- st_data  in  DATA_WIDTH  CPU store data.
- cpu_rst  out  1  reset to CPUTop, active high.
- running  out  1  high while in RUN.
- done  out  1  high in any terminal state.
- pass  out  1  run ended with tohost == 1.
- fail  out  1  run ended with odd tohost other than 1, or even nonzero tohost.
- timeout  out  1  run ended by the watchdog.
- fail_code  out  DATA_WIDTH  st_data >> 1 captured on fail; otherwise 0.
- cycle_count  out  CNT_WIDTH  cycles spent in RUN; frozen in terminal states.

## Operation
- States: RESET, RUN, PASS, FAIL, TIMEOUT. PASS, FAIL and TIMEOUT are terminal.
- rst high overrides everything and has these effects at that edge:
  - state becomes RESET and rcnt becomes 0.
  - cpu_rst becomes 1.
  - running, done, pass, fail and timeout become 0.
  - fail_code and cycle_count become 0.
- RESET: each edge with rst low does one of two things:
  - If rcnt == RESET_CYCLES-1: go to RUN, cpu_rst becomes 0, cycle_count becomes 0, running becomes 1.
  - Otherwise: rcnt increments.
- RUN: a tohost hit is st_en && st_addr == TOHOST_ADDR && st_data != 0.
  - Hit with st_data == 1: go to PASS.
  - Hit with any other nonzero value: go to FAIL and capture fail_code = st_data >> 1.
  - Store to TOHOST_ADDR with data 0: ignored. Stores to other addresses: ignored.
  - No hit and cycle_count == TIMEOUT_CYCLES-1: go to TIMEOUT.
  - Otherwise: cycle_count increments.
- Hit and timeout on the same edge: the hit wins (PASS or FAIL). cycle_count does not increment on that edge.
- On entering any terminal state:
  - cpu_rst becomes 1, which holds the core.
  - running becomes 0 and done becomes 1.
  - Exactly one of pass, fail or timeout is set.
- Terminal states are sticky. st_en is ignored there.
- restart in a terminal state goes to RESET with rcnt = 0 and clears these outputs: done, pass, fail, timeout, fail_code.
  - cycle_count keeps its old value until the next RESET→RUN transition.
  - restart in RESET or RUN is ignored.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Timing
- Reset values: cpu_rst = 1; all other outputs 0.
- cpu_rst falls exactly RESET_CYCLES edges after the last edge with rst high.
- Verdict latency: the tohost store sampled at edge N produces done, pass/fail and cpu_rst = 1 visible after edge N, with no extra stage.
- Timeout: with no hit, timeout rises on the TIMEOUT_CYCLES-th edge in RUN; cycle_count then reads TIMEOUT_CYCLES-1.
- rst asserted mid-RUN aborts the run at that edge; no verdict is produced.
- restart to cpu_rst low takes RESET_CYCLES+1 edges: 1 edge to re-enter RESET, then RESET_CYCLES edges of counting.

## Test plan
- Reset sequence: RESET_CYCLES=4, rst high for 2 cycles then low → cpu_rst stays 1 for exactly 4 edges, then 0; running = 1; all verdict outputs 0.
- Pass: store 1 to 0x1000 on the 10th RUN edge → pass = 1, done = 1, cpu_rst = 1, cycle_count = 9, fail = 0, timeout = 0; outputs stay stable for 20 more cycles.
- Fail and filtering: store 0 to 0x1000, then 7 to 0x0FFC, then 7 to 0x1000 → only the last store ends the run: fail = 1, fail_code = 3.
- Timeout and collision: TIMEOUT_CYCLES=100 with no store → timeout = 1 on the 100th edge with cycle_count = 99. Rerun with a store of 1 to 0x1000 on that same 100th edge → pass = 1, timeout = 0.
- Restart: after PASS, pulse restart → done = 0, cpu_rst remains 1 for 5 edges then 0, cycle_count restarts from 0. A restart pulse during RUN has no effect.
- Abort: assert rst on RUN edge 50 with a simultaneous tohost store of 1 → state RESET, pass = 0, cycle_count = 0, cpu_rst = 1.
